// File: rtl/itch_msg_ctrl.sv
// Beat sequencer for the ITCH message assembly buffer: steers MoldUDP64 beats into
// the 7-slot storage, detects completion and holds the message for the decoder.
module itch_msg_ctrl #(
  parameter int AXI_DATA_W = 64,
  parameter int AXI_KEEP_W = AXI_DATA_W / 8,
  parameter int MSG_MAX_B  = 50,
  parameter int CNT_MAX    = 7,
  parameter int MLEN_W     = 16,
  parameter int BCNT_W     = MLEN_W - $clog2(AXI_KEEP_W)
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              mold_v_i,
  input  logic              mold_start_i,
  input  logic [MLEN_W-1:0] mold_len_i,
  output logic              mold_ready_o,
  output logic [CNT_MAX-1:0] slot_en_o,
  output logic [2:0]        slot_cnt_o,
  output logic              msg_v_o,
  output logic [MLEN_W-1:0] msg_len_o,
  input  logic              msg_ready_i,
  output logic              err_len_o,
  output logic              err_trunc_o
);

  localparam int LOG2_KEEP = $clog2(AXI_KEEP_W);
  localparam int EXP_W     = BCNT_W + 1;

  typedef enum logic [1:0] {IDLE, RECV, DONE, DROP} state_t;

  state_t              state;
  logic [BCNT_W-1:0]   bcnt;
  logic [BCNT_W-1:0]   bcnt_nxt;
  logic [EXP_W-1:0]    exp_beats;
  logic [EXP_W-1:0]    exp_new;
  logic [EXP_W-1:0]    bcnt_inc;
  logic [MLEN_W:0]     exp_sum;
  logic                acc;
  logic                len_bad;
  logic                last_beat;
  logic [CNT_MAX-1:0]  slot_hit;

  assign mold_ready_o = (state != DONE) | msg_ready_i;
  assign acc          = mold_v_i & mold_ready_o;
  assign len_bad      = (mold_len_i == '0) | (mold_len_i > MLEN_W'(MSG_MAX_B));

  // Beat count of the new message, one extra bit so a 65535-byte length cannot wrap.
  assign exp_sum   = {1'b0, mold_len_i} + (MLEN_W + 1)'(AXI_KEEP_W - 1);
  assign exp_new   = EXP_W'(exp_sum >> LOG2_KEEP);
  assign bcnt_inc  = {1'b0, bcnt} + EXP_W'(1);
  assign last_beat = (bcnt_inc == exp_beats);
  assign bcnt_nxt  = (&bcnt) ? bcnt : bcnt + BCNT_W'(1);

  for (genvar gi = 0; gi < CNT_MAX; gi++) begin : g_slot
    assign slot_hit[gi] = (bcnt == BCNT_W'(gi));
  end

  // Write enables follow the accepted beat combinationally; forced low while in reset.
  always_comb begin
    slot_en_o = '0;
    if (nreset && acc) begin
      if (mold_start_i) begin
        slot_en_o[0] = ~len_bad;
      end else if (state == RECV) begin
        slot_en_o = slot_hit;
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state       <= IDLE;
      bcnt        <= '0;
      exp_beats   <= '0;
      msg_v_o     <= 1'b0;
      msg_len_o   <= '0;
      slot_cnt_o  <= '0;
      err_len_o   <= 1'b0;
      err_trunc_o <= 1'b0;
    end else begin
      err_len_o   <= 1'b0;
      err_trunc_o <= 1'b0;
      if (acc && mold_start_i) begin
        // A start beat is handled identically in every state; only RECV reports truncation.
        exp_beats   <= exp_new;
        err_trunc_o <= (state == RECV);
        if (len_bad) begin
          err_len_o  <= 1'b1;
          msg_v_o    <= 1'b0;
          slot_cnt_o <= '0;
          if (exp_new > EXP_W'(1)) begin
            state <= DROP;
            bcnt  <= BCNT_W'(1);
          end else begin
            state <= IDLE;
            bcnt  <= '0;
          end
        end else begin
          bcnt       <= BCNT_W'(1);
          msg_len_o  <= mold_len_i;
          slot_cnt_o <= 3'd1;
          if (exp_new == EXP_W'(1)) begin
            state   <= DONE;
            msg_v_o <= 1'b1;
          end else begin
            state   <= RECV;
            msg_v_o <= 1'b0;
          end
        end
      end else begin
        case (state)
          RECV: begin
            if (acc) begin
              bcnt       <= bcnt_nxt;
              slot_cnt_o <= bcnt_nxt[2:0];
              if (last_beat) begin
                state   <= DONE;
                msg_v_o <= 1'b1;
              end
            end
          end
          DONE: begin
            if (msg_ready_i) begin
              state   <= IDLE;
              msg_v_o <= 1'b0;
            end
          end
          DROP: begin
            if (acc) begin
              bcnt <= bcnt_nxt;
              if (last_beat) begin
                state      <= IDLE;
                slot_cnt_o <= bcnt_nxt[2:0];
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_itch_msg_ctrl.sv
// Bench for itch_msg_ctrl: directed scenarios with literal expectations, then random
// traffic checked every cycle against a message-level reference model.
module tb_itch_msg_ctrl;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        mold_v = 1'b0;
  logic        mold_start = 1'b0;
  logic [15:0] mold_len = '0;
  logic        mold_ready;
  logic [6:0]  slot_en;
  logic [2:0]  slot_cnt;
  logic        msg_v;
  logic [15:0] msg_len;
  logic        msg_ready = 1'b0;
  logic        err_len;
  logic        err_trunc;

  int tests = 0;
  int fails = 0;

  itch_msg_ctrl dut (
    .clk          (clk),
    .nreset       (nreset),
    .mold_v_i     (mold_v),
    .mold_start_i (mold_start),
    .mold_len_i   (mold_len),
    .mold_ready_o (mold_ready),
    .slot_en_o    (slot_en),
    .slot_cnt_o   (slot_cnt),
    .msg_v_o      (msg_v),
    .msg_len_o    (msg_len),
    .msg_ready_i  (msg_ready),
    .err_len_o    (err_len),
    .err_trunc_o  (err_trunc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: what message is in flight and how many beats it has seen.
  bit m_recv, m_hold, m_drop;
  int m_need, m_got, m_msg_len;
  bit m_err_len, m_err_trunc;

  always @(negedge clk) begin
    bit e_ready, a, good;
    int e_slot;
    if (!nreset) begin
      m_recv = 0; m_hold = 0; m_drop = 0; m_need = 0; m_got = 0; m_msg_len = 0;
      m_err_len = 0; m_err_trunc = 0;
      chk("rst_msg_v", msg_v, 0);
      chk("rst_msg_len", msg_len, 0);
      chk("rst_err_len", err_len, 0);
      chk("rst_err_trunc", err_trunc, 0);
      chk("rst_slot_en", slot_en, 0);
      chk("rst_ready", mold_ready, 1);
      chk("rst_slot_cnt", slot_cnt, 0);
    end else begin
      e_ready = !m_hold || msg_ready;
      a       = mold_v && e_ready;
      good    = (mold_len >= 1) && (mold_len <= 50);
      e_slot  = 0;
      if (a && mold_start && good) e_slot = 1;
      else if (a && !mold_start && m_recv) e_slot = 1 << m_got;

      chk("ready", mold_ready, int'(e_ready));
      chk("slot_en", slot_en, e_slot);
      chk("msg_v", msg_v, int'(m_hold));
      chk("err_len", err_len, int'(m_err_len));
      chk("err_trunc", err_trunc, int'(m_err_trunc));
      if (m_hold) chk("msg_len", msg_len, m_msg_len);
      if (m_hold || m_recv) chk("slot_cnt", slot_cnt, m_got % 8);
      if (m_drop) chk("slot_cnt_drop", slot_cnt, 0);

      m_err_len = 0;
      m_err_trunc = 0;
      if (a && mold_start) begin
        m_err_trunc = m_recv;
        m_recv = 0; m_hold = 0; m_drop = 0;
        m_need = (int'(mold_len) + 7) / 8;
        m_got = 1;
        if (!good) begin
          m_err_len = 1;
          m_drop = (m_need > 1);
        end else begin
          m_msg_len = mold_len;
          if (m_need == 1) m_hold = 1; else m_recv = 1;
        end
      end else if (a && m_recv) begin
        m_got++;
        if (m_got == m_need) begin m_recv = 0; m_hold = 1; end
      end else if (a && m_drop) begin
        m_got++;
        if (m_got == m_need) m_drop = 0;
      end else if (m_hold && msg_ready) begin
        m_hold = 0;
      end
    end
  end

  task automatic step(input bit v, input bit s, input int len, input bit rdy);
    @(posedge clk);
    #1;
    mold_v = v; mold_start = s; mold_len = 16'(len); msg_ready = rdy;
    @(negedge clk);
  endtask

  initial begin
    @(posedge clk);
    #1 nreset = 1'b1;

    // 1: 36-byte message into five slots, decoder stalled
    step(1, 1, 36, 0); chk("t1_slot0", slot_en, 'h01);
    step(1, 0, 0, 0);  chk("t1_slot1", slot_en, 'h02);
    step(1, 0, 0, 0);  chk("t1_slot2", slot_en, 'h04);
    step(1, 0, 0, 0);  chk("t1_slot3", slot_en, 'h08);
    step(1, 0, 0, 0);  chk("t1_slot4", slot_en, 'h10);
    step(0, 0, 0, 0);
    chk("t1_msg_v", msg_v, 1); chk("t1_msg_len", msg_len, 36);
    chk("t1_slot_cnt", slot_cnt, 5); chk("t1_ready", mold_ready, 0);

    // 2: hold, then consume with a same-cycle 8-byte start
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);  chk("t2_hold", msg_v, 1);
    step(1, 1, 8, 1);  chk("t2_slot", slot_en, 'h01); chk("t2_ready", mold_ready, 1);
    step(0, 0, 0, 0);  chk("t2_msg_v", msg_v, 1); chk("t2_msg_len", msg_len, 8);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);  chk("t2_consumed", msg_v, 0);

    // 3: oversize message dropped, then zero length
    step(1, 1, 60, 0); chk("t3_slot_start", slot_en, 0);
    for (int i = 0; i < 7; i++) begin
      step(1, 0, 0, 0);
      chk("t3_slot_drop", slot_en, 0);
      chk("t3_err_len", err_len, (i == 0) ? 1 : 0);
    end
    step(0, 0, 0, 0);  chk("t3_msg_v", msg_v, 0); chk("t3_err_once", err_len, 0);
    step(1, 1, 0, 0);  chk("t3_zero_slot", slot_en, 0);
    step(0, 0, 0, 0);  chk("t3_zero_err", err_len, 1); chk("t3_zero_msg_v", msg_v, 0);

    // 4: truncation by a new start
    step(1, 1, 36, 0);
    step(1, 0, 0, 0);
    step(1, 1, 8, 0);  chk("t4_slot", slot_en, 'h01);
    step(0, 0, 0, 0);
    chk("t4_trunc", err_trunc, 1); chk("t4_msg_v", msg_v, 1);
    chk("t4_msg_len", msg_len, 8); chk("t4_slot_cnt", slot_cnt, 1);
    step(0, 0, 0, 1);

    // 5: back-to-back with decoder always ready
    step(1, 1, 8, 1);  chk("t5_ready_a", mold_ready, 1);
    step(1, 1, 16, 1); chk("t5_msg_v_a", msg_v, 1); chk("t5_len_a", msg_len, 8);
    chk("t5_ready_b", mold_ready, 1); chk("t5_slot_b", slot_en, 'h01);
    step(1, 0, 0, 1);  chk("t5_slot_c", slot_en, 'h02); chk("t5_ready_c", mold_ready, 1);
    step(0, 0, 0, 1);  chk("t5_msg_v_b", msg_v, 1); chk("t5_len_b", msg_len, 16);
    step(0, 0, 0, 0);

    // 6: async reset mid-message, stray beat, fresh message
    step(1, 1, 36, 0);
    step(1, 0, 0, 0);
    @(posedge clk);
    #1 mold_v = 1; mold_start = 0; msg_ready = 0;
    #2 nreset = 1'b0;
    #1;
    chk("t6_slot_en", slot_en, 0); chk("t6_msg_v", msg_v, 0);
    chk("t6_ready", mold_ready, 1); chk("t6_slot_cnt", slot_cnt, 0);
    @(posedge clk);
    #1 nreset = 1'b1;
    @(negedge clk);    chk("t6_stray", slot_en, 0);
    step(1, 1, 16, 0); chk("t6_slot0", slot_en, 'h01);
    step(1, 0, 0, 0);  chk("t6_slot1", slot_en, 'h02);
    step(0, 0, 0, 0);  chk("t6_msg_v_new", msg_v, 1); chk("t6_len", msg_len, 16);
    step(0, 0, 0, 1);

    // Random traffic: alternate stalling decoder and always-ready decoder
    for (int i = 0; i < 4000; i++) begin
      bit v, s, rdy;
      int len, r;
      v = ($urandom_range(0, 99) < 75);
      s = ($urandom_range(0, 99) < 15);
      r = $urandom_range(0, 99);
      if (r < 80)      len = $urandom_range(1, 50);
      else if (r < 88) len = 0;
      else if (r < 96) len = $urandom_range(51, 80);
      else             len = $urandom_range(0, 65535);
      rdy = ((i / 500) % 2 == 1) ? 1'b1 : ($urandom_range(0, 99) < 50);
      step(v, s, len, rdy);
    end

    step(0, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
